ips2l_pcie_dma_mrd_req_sched: RTL and testbench
===============================================

// Module: ips2l_pcie_dma_mrd_req_sched
// PURPOSE
//  Round-robin scheduler sharing the MRd TLP transmit controller between NUM_CH DMA read channels.
//  Grants one channel at a time and splits its request at 4 KB address boundaries.
//  Selects MRd32 when addr[63:32]==0, otherwise MRd64.
//  Drives the controller's level req/ack handshake and stalls while the tag pool is full.
//  Sits between the DMA channel registers and the MRd TX controller; MRRS splitting stays downstream.
// PARAMETERS
//  NUM_CH  4  number of read channels (2..8)
//  CH_W    2  grant index width, equals clog2(NUM_CH)
// PORTS
//  clk              in   1          core clock (gen1 62.5 MHz, gen2 125 MHz)
//  rst              in   1          synchronous, active-high reset
//  i_ch_req         in   NUM_CH     per-channel read request, level; held until o_ch_done
//  i_ch_addr        in   NUM_CH*64  per-channel byte start address; [1:0] ignored, forced 0
//  i_ch_length      in   NUM_CH*10  per-channel length in DW, 0..1023
//  o_ch_done        out  NUM_CH     1-cycle pulse when the channel's full length has been handed off
//  i_tag_full       in   1          downstream tag pool full
//  o_mrd32_req      out  1          MRd32 request to TX controller
//  i_mrd32_req_ack  in   1          ack for o_mrd32_req
//  o_mrd64_req      out  1          MRd64 request to TX controller
//  i_mrd64_req_ack  in   1          ack for o_mrd64_req
//  o_req_length     out  10         chunk length in DW; valid while a req is high
//  o_req_addr       out  64         chunk byte address; valid while a req is high
//  o_grant_ch       out  CH_W       channel currently granted
//  o_active         out  1          high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset:
//   - all outputs 0; FSM enters IDLE; RR pointer = 0.
//   - Reset mid-transfer abandons the chunk with no o_ch_done pulse; req drops at the first edge with rst high.
//  FSM states: IDLE, CALC, REQ, REL.
//   - IDLE: when |i_ch_req, grant the first requester at or after the RR pointer (wrap NUM_CH-1 -> 0).
//     Latch its addr into cur_addr and its length into rem_len; go to CALC.
//     If the latched length is 0, pulse o_ch_done[g] in CALC and return to IDLE with no downstream req.
//   - CALC: dw_to_bnd = 1024 - cur_addr[11:2] (11b, 1..1024); chunk = min(rem_len, dw_to_bnd).
//     Register chunk into o_req_length and cur_addr into o_req_addr. Stay in CALC while i_tag_full.
//     Otherwise go to REQ, asserting o_mrd64_req if cur_addr[63:32]!=0, else o_mrd32_req.
//   - REQ: hold req, length and addr stable until the matching ack is seen high.
//     Then drop req, keep addr and length stable, and go to REL.
//   - REL: wait for ack low. On ack low: rem_len -= chunk; cur_addr += {chunk,2'b00} (64b add, carry into the upper word).
//     If rem_len==0: pulse o_ch_done[g], set RR pointer = g+1 (wrap), go to IDLE. Else go to CALC.
//  Handshake: never assert both reqs; never re-assert a req before the previous ack has fallen.
//  Stall: the controller acks only when not busy, so REQ may wait many cycles; no timeout.
//  Channel changes: i_ch_req or addr changes of a granted channel mid-transfer are ignored until its done.
//   A channel that drops i_ch_req before grant is simply skipped.
//  Latency: i_ch_req rise in IDLE -> o_mrdXX_req high 2 cycles later with i_tag_full low.
//   Ack low -> next chunk req 2 cycles later.
//  Simultaneous: i_tag_full rising in REQ does not retract the pending req.
//   A done pulse and a new grant never occur in the same cycle (IDLE is visited).
// STRUCTURE
//  - ips2l_pcie_dma_pkg: FSM state encodings, BND_DW = 11'd1024, DW-to-byte shift constant.
//  - Sub-module ips2l_pcie_dma_rr_arb (NUM_CH): combinational first-set-at-or-after-pointer search.
//    Outputs grant index and valid.
//  - Top level holds the FSM, the cur_addr/rem_len counters and the output registers.
// TESTING
//  1. ch0 addr 0x1000, len 16 -> one o_mrd32_req, len 16, addr 0x1000; ack cycle -> o_ch_done[0] 1 cycle.
//  2. ch2 addr 0x1_0000_0FC0, len 32 -> o_mrd64_req len 16 @0x1_0000_0FC0, then len 16 @0x1_0000_1000; one done.
//  3. ch0..ch3 req together, pointer 0 -> grants 0,1,2,3; ch0 and ch1 re-req after grant 3 -> ch0 then ch1.
//  4. i_tag_full high for 20 cycles while in CALC -> no req; release -> req high 1 cycle later.
//  5. ch1 len 0 -> o_ch_done[1] pulse, no mrd req; ch1 len 1023 @0x800 -> chunks 512, 511.
//  6. rst high in REQ with ack high -> next cycle all outputs 0, FSM in IDLE, no done pulse; RR pointer 0.

Source files
------------

// File: rtl/ips2l_pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA MRd request scheduler: FSM encoding,
// 4 KB boundary constants and the per-chunk length helper.
package ips2l_pcie_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_REQ  = 2'd2,
    ST_REL  = 2'd3
  } sched_state_e;

  localparam logic [10:0] BND_DW   = 11'd1024;
  localparam int          DW_SHIFT = 2;

  // Chunk never crosses a 4 KB page; dw_to_bnd is 1..1024 and rem_len <= 1023,
  // so the result always fits in 10 bits.
  function automatic logic [9:0] chunk_len(input logic [9:0] rem_len,
                                           input logic [9:0] page_dw);
    logic [10:0] dw_to_bnd;
    dw_to_bnd = BND_DW - {1'b0, page_dw};
    chunk_len = ({1'b0, rem_len} < dw_to_bnd) ? rem_len : dw_to_bnd[9:0];
  endfunction

endpackage

// File: rtl/ips2l_pcie_dma_rr_arb.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping from NUM_CH-1 back to 0.
module ips2l_pcie_dma_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              valid
);

  logic [CH_W-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // Scan farthest offset first so the nearest requester is the last writer.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ips2l_pcie_dma_mrd_req_sched.sv
// Round-robin MRd request scheduler: grants one DMA read channel at a time,
// splits its request at 4 KB boundaries and drives the MRd32/MRd64 req/ack pair.
module ips2l_pcie_dma_mrd_req_sched
  import ips2l_pcie_dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    i_ch_req,
  input  logic [NUM_CH*64-1:0] i_ch_addr,
  input  logic [NUM_CH*10-1:0] i_ch_length,
  output logic [NUM_CH-1:0]    o_ch_done,
  input  logic                 i_tag_full,
  output logic                 o_mrd32_req,
  input  logic                 i_mrd32_req_ack,
  output logic                 o_mrd64_req,
  input  logic                 i_mrd64_req_ack,
  output logic [9:0]           o_req_length,
  output logic [63:0]          o_req_addr,
  output logic [CH_W-1:0]      o_grant_ch,
  output logic                 o_active
);

  sched_state_e    state, state_nxt;
  logic [63:0]     cur_addr;
  logic [9:0]      rem_len;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] arb_grant;
  logic            arb_valid;
  logic [CH_W-1:0] next_ptr;
  logic            req_is64;
  logic            ack_sel;
  logic            last_chunk;
  logic [9:0]      chunk;
  logic [NUM_CH-1:0] grant_onehot;

  logic [63:0] ch_addr [NUM_CH];
  logic [9:0]  ch_len  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_addr[c] = i_ch_addr[c*64 +: 64];
    assign ch_len[c]  = i_ch_length[c*10 +: 10];
  end

  ips2l_pcie_dma_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arb (
    .req   (i_ch_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // The ack to watch in REQ/REL follows the request type issued from CALC.
  assign ack_sel      = req_is64 ? i_mrd64_req_ack : i_mrd32_req_ack;
  assign last_chunk   = (rem_len == o_req_length);
  assign chunk        = chunk_len(rem_len, cur_addr[11:2]);
  assign next_ptr     = (o_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : o_grant_ch + CH_W'(1);
  assign grant_onehot = NUM_CH'(1) << o_grant_ch;
  assign o_active     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (arb_valid) state_nxt = ST_CALC;
      ST_CALC: begin
        if (rem_len == '0)    state_nxt = ST_IDLE;
        else if (!i_tag_full) state_nxt = ST_REQ;
      end
      ST_REQ:  if (ack_sel) state_nxt = ST_REL;
      ST_REL:  if (!ack_sel) state_nxt = last_chunk ? ST_IDLE : ST_CALC;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr     <= '0;
      rem_len      <= '0;
      rr_ptr       <= '0;
      o_grant_ch   <= '0;
      o_req_length <= '0;
      o_req_addr   <= '0;
      o_mrd32_req  <= 1'b0;
      o_mrd64_req  <= 1'b0;
      req_is64     <= 1'b0;
      o_ch_done    <= '0;
    end else begin
      o_ch_done <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            o_grant_ch <= arb_grant;
            cur_addr   <= ch_addr[arb_grant] & ~64'h3;
            rem_len    <= ch_len[arb_grant];
          end
        end
        ST_CALC: begin
          o_req_length <= chunk;
          o_req_addr   <= cur_addr;
          if (rem_len == '0) begin
            o_ch_done <= grant_onehot;
            rr_ptr    <= next_ptr;
          end else if (!i_tag_full) begin
            req_is64    <= |cur_addr[63:32];
            o_mrd64_req <= |cur_addr[63:32];
            o_mrd32_req <= ~|cur_addr[63:32];
          end
        end
        ST_REQ: begin
          if (ack_sel) begin
            o_mrd32_req <= 1'b0;
            o_mrd64_req <= 1'b0;
          end
        end
        ST_REL: begin
          // Counters advance only once the controller has released the ack.
          if (!ack_sel) begin
            rem_len  <= rem_len - o_req_length;
            cur_addr <= cur_addr + (64'(o_req_length) << DW_SHIFT);
            if (last_chunk) begin
              o_ch_done <= grant_onehot;
              rr_ptr    <= next_ptr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ips2l_pcie_dma_mrd_req_sched.sv
// Self-checking bench for the MRd request scheduler: directed scenarios with
// literal expectations plus a per-cycle scoreboard built from page-split arithmetic.
module tb_ips2l_pcie_dma_mrd_req_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    i_ch_req;
  logic [NUM_CH*64-1:0] i_ch_addr;
  logic [NUM_CH*10-1:0] i_ch_length;
  logic [NUM_CH-1:0]    o_ch_done;
  logic                 i_tag_full;
  logic                 o_mrd32_req;
  logic                 i_mrd32_req_ack;
  logic                 o_mrd64_req;
  logic                 i_mrd64_req_ack;
  logic [9:0]           o_req_length;
  logic [63:0]          o_req_addr;
  logic [CH_W-1:0]      o_grant_ch;
  logic                 o_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_lat = 1, rel_lat = 1, ack_wait = 0, rel_wait = 0, ack_fall_cyc = 0;

  always #5 clk = ~clk;

  ips2l_pcie_dma_mrd_req_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_ch_req        (i_ch_req),
    .i_ch_addr       (i_ch_addr),
    .i_ch_length     (i_ch_length),
    .o_ch_done       (o_ch_done),
    .i_tag_full      (i_tag_full),
    .o_mrd32_req     (o_mrd32_req),
    .i_mrd32_req_ack (i_mrd32_req_ack),
    .o_mrd64_req     (o_mrd64_req),
    .i_mrd64_req_ack (i_mrd64_req_ack),
    .o_req_length    (o_req_length),
    .o_req_addr      (o_req_addr),
    .o_grant_ch      (o_grant_ch),
    .o_active        (o_active)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: channels drop their request on done, controller model answers the handshake.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    i_ch_req = i_ch_req & ~o_ch_done;
    if (!(i_mrd32_req_ack || i_mrd64_req_ack)) begin
      if (o_mrd32_req || o_mrd64_req) begin
        if (ack_wait >= ack_lat) begin
          i_mrd32_req_ack = o_mrd32_req;
          i_mrd64_req_ack = o_mrd64_req;
          ack_wait = 0;
        end else ack_wait++;
      end
    end else if (!(o_mrd32_req || o_mrd64_req)) begin
      if (rel_wait >= rel_lat) begin
        i_mrd32_req_ack = 1'b0;
        i_mrd64_req_ack = 1'b0;
        rel_wait = 0;
        ack_fall_cyc = cyc;
      end else rel_wait++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_ch_req = '0;
    i_tag_full = 1'b0;
    i_mrd32_req_ack = 1'b0;
    i_mrd64_req_ack = 1'b0;
    ack_wait = 0;
    rel_wait = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [63:0] addr, input logic [9:0] len);
    i_ch_addr[c*64 +: 64] = addr;
    i_ch_length[c*10 +: 10] = len;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 200 && (o_mrd32_req || o_mrd64_req); i++) step();
    for (int i = 0; i < 200 && !(o_mrd32_req || o_mrd64_req); i++) step();
    check(name, 64'(o_mrd32_req || o_mrd64_req), 64'd1);
  endtask

  task automatic wait_done(input int c, input string name);
    for (int i = 0; i < 300 && !o_ch_done[c[CH_W-1:0]]; i++) step();
    check(name, 64'(o_ch_done), 64'(1 << c));
  endtask

  // Scoreboard: expected grant from the round-robin rule, expected chunk list
  // from splitting [addr, addr+4*len) at every 4096-byte page.
  initial begin : compare
    logic [NUM_CH-1:0]    p_req;
    logic [NUM_CH*64-1:0] p_addr;
    logic [NUM_CH*10-1:0] p_len;
    logic                 p_act, p_r32, p_r64;
    logic [9:0]           p_rlen;
    logic [63:0]          p_raddr;
    logic [CH_W-1:0]      idx;
    int                   m_ptr, m_g, g, rem, to_bnd, c;
    bit                   m_busy;
    logic [63:0]          a;
    logic [63:0]          q_addr[$];
    int                   q_len[$];
    p_req = '0; p_addr = '0; p_len = '0;
    p_act = 0; p_r32 = 0; p_r64 = 0; p_rlen = '0; p_raddr = '0;
    m_ptr = 0; m_g = 0; m_busy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ptr = 0; m_busy = 0;
        q_addr.delete(); q_len.delete();
        p_act = 0; p_r32 = 0; p_r64 = 0;
      end else begin
        if (o_active && !p_act) begin
          g = -1;
          for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((m_ptr + k) % NUM_CH);
            if (g < 0 && p_req[idx]) g = int'(idx);
          end
          check("sb_grant_ch", 64'(o_grant_ch), 64'(g));
          check("sb_grant_while_busy", 64'(m_busy), 64'd0);
          if (g >= 0) begin
            a = p_addr[g*64 +: 64] & ~64'h3;
            rem = int'(p_len[g*10 +: 10]);
            while (rem > 0) begin
              to_bnd = int'((64'd4096 - (a % 64'd4096)) / 64'd4);
              c = (rem < to_bnd) ? rem : to_bnd;
              q_addr.push_back(a);
              q_len.push_back(c);
              a = a + 64'(c) * 64'd4;
              rem = rem - c;
            end
            m_busy = 1;
            m_g = g;
          end
        end
        check("sb_one_req", 64'(o_mrd32_req && o_mrd64_req), 64'd0);
        if ((o_mrd32_req || o_mrd64_req) && !(p_r32 || p_r64)) begin
          check("sb_req_expected", 64'(q_addr.size() > 0), 64'd1);
          if (q_addr.size() > 0) begin
            check("sb_req_addr", o_req_addr, q_addr[0]);
            check("sb_req_len", 64'(o_req_length), 64'(q_len[0]));
            check("sb_req_is64", 64'(o_mrd64_req), 64'(q_addr[0][63:32] != 32'd0));
          end
        end else if ((o_mrd32_req || o_mrd64_req) && (p_r32 || p_r64)) begin
          check("sb_req_hold", 64'({o_req_addr, o_req_length, o_mrd32_req, o_mrd64_req}
                                   == {p_raddr, p_rlen, p_r32, p_r64}), 64'd1);
        end
        if (!(o_mrd32_req || o_mrd64_req) && (p_r32 || p_r64) && q_addr.size() > 0) begin
          void'(q_addr.pop_front());
          void'(q_len.pop_front());
        end
        if (o_ch_done != '0) begin
          check("sb_done_ch", 64'(o_ch_done), 64'(1 << m_g));
          check("sb_done_busy", 64'(m_busy), 64'd1);
          check("sb_done_chunks_left", 64'(q_addr.size()), 64'd0);
          check("sb_done_in_idle", 64'(o_active), 64'd0);
          m_ptr = (m_g + 1) % NUM_CH;
          m_busy = 0;
        end
        p_act = o_active; p_r32 = o_mrd32_req; p_r64 = o_mrd64_req;
        p_rlen = o_req_length; p_raddr = o_req_addr;
      end
      p_req = i_ch_req; p_addr = i_ch_addr; p_len = i_ch_length;
    end
  end

  initial begin : main
    int t0, n;
    bit saw, pa;
    int order[6];
    int exp_order[6];
    i_ch_addr = '0;
    i_ch_length = '0;
    do_reset();

    // Reset state
    check("rst_mrd32", 64'(o_mrd32_req), 64'd0);
    check("rst_mrd64", 64'(o_mrd64_req), 64'd0);
    check("rst_active", 64'(o_active), 64'd0);
    check("rst_done", 64'(o_ch_done), 64'd0);
    check("rst_len_addr", 64'(o_req_length) | o_req_addr, 64'd0);

    // 1: single MRd32 chunk, request latency 2
    set_ch(0, 64'h1000, 10'd16);
    i_ch_req[0] = 1'b1;
    t0 = cyc;
    wait_req("t1_req");
    check("t1_latency", 64'(cyc - t0), 64'd2);
    check("t1_mrd32", 64'({o_mrd32_req, o_mrd64_req}), 64'b10);
    check("t1_len", 64'(o_req_length), 64'd16);
    check("t1_addr", o_req_addr, 64'h1000);
    wait_done(0, "t1_done");
    step();
    check("t1_done_1cyc", 64'(o_ch_done), 64'd0);

    // 2: MRd64 split at a 4 KB page
    set_ch(2, 64'h1_0000_0FC0, 10'd32);
    i_ch_req[2] = 1'b1;
    wait_req("t2_req_a");
    check("t2_mrd64_a", 64'({o_mrd32_req, o_mrd64_req}), 64'b01);
    check("t2_len_a", 64'(o_req_length), 64'd16);
    check("t2_addr_a", o_req_addr, 64'h1_0000_0FC0);
    wait_req("t2_req_b");
    check("t2_len_b", 64'(o_req_length), 64'd16);
    check("t2_addr_b", o_req_addr, 64'h1_0000_1000);
    wait_done(2, "t2_done");

    // 3: round-robin order with re-requests after grant 3
    do_reset();
    ack_lat = 0; rel_lat = 0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 64'(c) * 64'h100, 10'd4);
    i_ch_req = '1;
    exp_order = '{0, 1, 2, 3, 0, 1};
    order = '{-1, -1, -1, -1, -1, -1};
    n = 0; pa = 0;
    for (int i = 0; i < 600 && n < 6; i++) begin
      step();
      if (o_active && !pa) begin
        order[n] = int'(o_grant_ch);
        n++;
        if (o_grant_ch == 2'd3) i_ch_req[1:0] = 2'b11;
      end
      pa = o_active;
    end
    for (int k = 0; k < 6; k++) check($sformatf("t3_rr_order_%0d", k), 64'(order[k]), 64'(exp_order[k]));
    wait_done(1, "t3_done_last");
    ack_lat = 1; rel_lat = 1;

    // 4: tag pool full holds the scheduler in CALC
    i_tag_full = 1'b1;
    set_ch(2, 64'h2000, 10'd8);
    i_ch_req[2] = 1'b1;
    saw = 0;
    repeat (22) begin
      step();
      saw |= (o_mrd32_req || o_mrd64_req);
    end
    check("t4_no_req_while_full", 64'(saw), 64'd0);
    check("t4_active_while_full", 64'(o_active), 64'd1);
    i_tag_full = 1'b0;
    step();
    check("t4_req_after_release", 64'(o_mrd32_req), 64'd1);
    wait_done(2, "t4_done");

    // 5: zero length, then 1023 DW across a page
    set_ch(1, 64'h3000, 10'd0);
    i_ch_req[1] = 1'b1;
    saw = 0;
    for (int i = 0; i < 50 && !o_ch_done[1]; i++) begin
      step();
      saw |= (o_mrd32_req || o_mrd64_req);
    end
    check("t5_len0_done", 64'(o_ch_done), 64'b0010);
    check("t5_len0_noreq", 64'(saw), 64'd0);
    step();
    set_ch(1, 64'h800, 10'd1023);
    i_ch_req[1] = 1'b1;
    wait_req("t5_req_a");
    check("t5_len_a", 64'(o_req_length), 64'd512);
    check("t5_addr_a", o_req_addr, 64'h800);
    wait_req("t5_req_b");
    check("t5_ack_to_req", 64'(cyc - ack_fall_cyc), 64'd2);
    check("t5_len_b", 64'(o_req_length), 64'd511);
    check("t5_addr_b", o_req_addr, 64'h1000);
    wait_done(1, "t5_done");

    // 6: reset while in REQ with the ack high
    ack_lat = 3;
    set_ch(2, 64'h4000, 10'd64);
    i_ch_req[2] = 1'b1;
    wait_req("t6_req");
    for (int i = 0; i < 20 && !i_mrd32_req_ack; i++) step();
    check("t6_req_with_ack", 64'({o_mrd32_req, i_mrd32_req_ack}), 64'b11);
    rst = 1'b1;
    i_ch_req = '0;
    @(posedge clk);
    #1;
    check("t6_rst_reqs", 64'({o_mrd32_req, o_mrd64_req}), 64'd0);
    check("t6_rst_active", 64'(o_active), 64'd0);
    check("t6_rst_done", 64'(o_ch_done), 64'd0);
    check("t6_rst_len_addr_grant", 64'(o_req_length) | o_req_addr | 64'(o_grant_ch), 64'd0);
    i_mrd32_req_ack = 1'b0;
    i_mrd64_req_ack = 1'b0;
    ack_wait = 0; rel_wait = 0; ack_lat = 1;
    rst = 1'b0;
    step();
    check("t6_no_done_after_rst", 64'(o_ch_done), 64'd0);
    set_ch(1, 64'h5000, 10'd4);
    set_ch(3, 64'h6000, 10'd4);
    i_ch_req = 4'b1010;
    step();
    check("t6_ptr0_grant", 64'({o_active, o_grant_ch}), 64'({1'b1, 2'd1}));
    wait_done(1, "t6_done_ch1");
    wait_done(3, "t6_done_ch3");

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
